// File: rtl/spi_core.sv
// Single-channel SPI master: shifts out an MSB-aligned word and returns the LSB-aligned received word.
// Frame width, CPOL/CPHA and the SCLK divider are captured when a word is accepted.
module spi_core #(
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_COUNT_WIDTH = 8,
  parameter int SCLK_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_COUNT_WIDTH-1:0] spi_width_i,
  input  logic                        cpol_i,
  input  logic                        cpha_i,
  input  logic [SCLK_COUNT_WIDTH-1:0] sclk_div_i,
  input  logic                        mosi_stb,
  input  logic [DATA_WIDTH-1:0]       mosi_data_i,
  output logic                        miso_stb,
  output logic [DATA_WIDTH-1:0]       miso_data_o,
  output logic                        ready_o,
  output logic [2:0]                  state_o,
  output logic [DATA_COUNT_WIDTH-1:0] data_count_o,
  output logic                        wr_edge,
  output logic                        rd_edge,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic                        csn
);

  typedef enum logic [2:0] {IDLE = 3'd0, LEAD = 3'd1, XFER = 3'd2, TRAIL = 3'd3, DONE = 3'd4} state_e;

  state_e                      state_q, state_d;
  logic [SCLK_COUNT_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic                        half_q, half_d;
  logic [DATA_COUNT_WIDTH-1:0] bitIdx_q, bitIdx_d, width_q, width_d, count_q, count_d;
  logic                        cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0]       txShift_q, txShift_d, rxShift_q, rxShift_d;
  logic [DATA_COUNT_WIDTH-1:0] widthClamp;
  logic                        accept, lastCnt, rdEv, wrEv;

  logic                        csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d, ready_q, ready_d;
  logic                        misoStb_q, misoStb_d, wrEdge_q, wrEdge_d, rdEdge_q, rdEdge_d;
  logic [DATA_WIDTH-1:0]       misoData_q, misoData_d;

  always_comb begin
    if (spi_width_i == '0)
      widthClamp = DATA_COUNT_WIDTH'(1);
    else if (spi_width_i > DATA_COUNT_WIDTH'(DATA_WIDTH))
      widthClamp = DATA_COUNT_WIDTH'(DATA_WIDTH);
    else
      widthClamp = spi_width_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      half_q     <= 1'b0;
      bitIdx_q   <= '0;
      width_q    <= '0;
      count_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      csn_q      <= 1'b1;
      sclk_q     <= cpol_i;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      misoStb_q  <= 1'b0;
      misoData_q <= '0;
      wrEdge_q   <= 1'b0;
      rdEdge_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      half_q     <= half_d;
      bitIdx_q   <= bitIdx_d;
      width_q    <= width_d;
      count_q    <= count_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      csn_q      <= csn_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      misoStb_q  <= misoStb_d;
      misoData_q <= misoData_d;
      wrEdge_q   <= wrEdge_d;
      rdEdge_q   <= rdEdge_d;
    end
  end

  // Each XFER slot is two halves of D+1 cycles; miso is captured entering the
  // second half and the next bit is presented when the slot index advances.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    half_d    = half_q;
    bitIdx_d  = bitIdx_q;
    width_d   = width_q;
    count_d   = count_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    rdEv      = 1'b0;
    wrEv      = 1'b0;
    accept    = mosi_stb & ready_q;
    lastCnt   = (cnt_q == div_q);
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d   = LEAD;
          cnt_d     = '0;
          half_d    = 1'b0;
          bitIdx_d  = '0;
          count_d   = '0;
          width_d   = widthClamp;
          cpol_d    = cpol_i;
          cpha_d    = cpha_i;
          div_d     = sclk_div_i;
          txShift_d = mosi_data_i;
          rxShift_d = '0;
        end
      end
      LEAD: begin
        cnt_d = cnt_q + SCLK_COUNT_WIDTH'(1);
        if (lastCnt) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        cnt_d = cnt_q + SCLK_COUNT_WIDTH'(1);
        if (lastCnt) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d    = 1'b1;
            rdEv      = 1'b1;
            rxShift_d = {rxShift_q[DATA_WIDTH-2:0], miso};
            count_d   = count_q + DATA_COUNT_WIDTH'(1);
          end else if (bitIdx_q == width_q - DATA_COUNT_WIDTH'(1)) begin
            state_d = TRAIL;
          end else begin
            half_d    = 1'b0;
            bitIdx_d  = bitIdx_q + DATA_COUNT_WIDTH'(1);
            wrEv      = 1'b1;
            txShift_d = {txShift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      TRAIL: begin
        cnt_d = cnt_q + SCLK_COUNT_WIDTH'(1);
        if (lastCnt) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next-state values so every pin comes straight from a flop.
  always_comb begin
    csn_d      = !(state_d inside {LEAD, XFER, TRAIL});
    ready_d    = (state_d == IDLE) || (state_d == DONE);
    misoStb_d  = (state_d == DONE);
    misoData_d = (state_d == DONE) ? rxShift_d : misoData_q;
    mosi_d     = csn_d ? 1'b0 : txShift_d[DATA_WIDTH-1];
    wrEdge_d   = wrEv;
    rdEdge_d   = rdEv;
    if (state_d == IDLE)
      sclk_d = cpol_i;
    else if (state_d == XFER)
      sclk_d = cpol_d ^ half_d ^ cpha_d;
    else
      sclk_d = cpol_d;
  end

  assign state_o      = state_q;
  assign data_count_o = count_q;
  assign csn          = csn_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ready_o      = ready_q;
  assign miso_stb     = misoStb_q;
  assign miso_data_o  = misoData_q;
  assign wr_edge      = wrEdge_q;
  assign rd_edge      = rdEdge_q;

endmodule

// File: tb/tb_spi_core.sv
// Loopback testbench for spi_core: random words, modes and widths checked against
// an arithmetic model of frame contents and frame length.
module tb_spi_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  spi_width_i;
  logic        cpol_i, cpha_i;
  logic [15:0] sclk_div_i;
  logic        mosi_stb;
  logic [15:0] mosi_data_i;
  logic        miso_stb;
  logic [15:0] miso_data_o;
  logic        ready_o;
  logic [2:0]  state_o;
  logic [7:0]  data_count_o;
  logic        wr_edge, rd_edge, sclk, mosi, miso, csn;

  int total = 0;
  int bad   = 0;
  logic curCpol, curCpha;

  // Frame statistics gathered by runFrame.
  logic [15:0] rx;
  int cyc, csnLow, toggles, rdCnt, wrCnt, sampleBad, cnt0, finalCount;
  bit timedOut;

  assign miso = mosi;

  always #5 clk = ~clk;

  spi_core dut (
    .clk(clk), .rst(rst), .spi_width_i(spi_width_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .sclk_div_i(sclk_div_i), .mosi_stb(mosi_stb), .mosi_data_i(mosi_data_i),
    .miso_stb(miso_stb), .miso_data_o(miso_data_o), .ready_o(ready_o), .state_o(state_o),
    .data_count_o(data_count_o), .wr_edge(wr_edge), .rd_edge(rd_edge), .sclk(sclk),
    .mosi(mosi), .miso(miso), .csn(csn)
  );

  function automatic logic [15:0] expRx(input logic [15:0] data, input int w);
    return data >> (16 - w);
  endfunction

  function automatic int expLen(input int w, input int d);
    return (w + 1) * 2 * (d + 1) + 1;
  endfunction

  // Sets up the configuration, lets idle sclk settle, then raises the strobe.
  task automatic startFrame(input logic [15:0] data, input int w, input logic cp, input logic ch, input int d);
    spi_width_i = 8'(w);
    cpol_i      = cp;
    cpha_i      = ch;
    sclk_div_i  = 16'(d);
    mosi_data_i = data;
    curCpol     = cp;
    curCpha     = ch;
    @(posedge clk); #1;
    mosi_stb = 1'b1;
  endtask

  // Consumes the accept edge, then follows the frame until miso_stb (left in the DONE cycle).
  task automatic runFrame(input int stbAt);
    logic prevSclk;
    @(posedge clk); #1;
    mosi_stb  = 1'b0;
    prevSclk  = curCpol;
    cyc = 1; csnLow = 0; toggles = 0; rdCnt = 0; wrCnt = 0; sampleBad = 0;
    timedOut = 1'b0;
    cnt0 = int'(data_count_o);
    forever begin
      if (!csn) csnLow++;
      if (sclk !== prevSclk) toggles++;
      prevSclk = sclk;
      if (rd_edge) begin
        rdCnt++;
        if (sclk !== (curCpha ? curCpol : ~curCpol)) sampleBad++;
      end
      if (wr_edge) wrCnt++;
      if (miso_stb) break;
      if (cyc == stbAt) begin
        mosi_stb    = 1'b1;
        mosi_data_i = ~mosi_data_i;
        spi_width_i = 8'd3;
      end
      if (cyc == stbAt + 1) mosi_stb = 1'b0;
      if (cyc > 3000) begin
        timedOut = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rx = miso_data_o;
    finalCount = int'(data_count_o);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpol_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL rst_state got=%0d exp=0", state_o); end
    total++; if (csn !== 1'b1 || ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_csn_ready got=%b%b exp=11", csn, ready_o); end
    total++; if (miso_stb !== 1'b0 || wr_edge !== 1'b0 || rd_edge !== 1'b0 || mosi !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_pulses got=%b%b%b%b exp=0000", miso_stb, wr_edge, rd_edge, mosi); end
    total++; if (miso_data_o !== 16'h0 || data_count_o !== 8'h0) begin
      bad++; $display("[TB] FAIL rst_data got=%h/%0d exp=0000/0", miso_data_o, data_count_o); end
    total++; if (sclk !== 1'b1) begin bad++; $display("[TB] FAIL rst_sclk got=%b exp=1", sclk); end
    cpol_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback;
    startFrame(16'hA53C, 8, 1'b0, 1'b0, 2);
    runFrame(-1);
    total++; if (timedOut) begin bad++; $display("[TB] FAIL loop_timeout got=%0d exp<=3000", cyc); end
    total++; if (rx !== 16'h00A5) begin bad++; $display("[TB] FAIL loop_data got=%h exp=00a5", rx); end
    total++; if (cyc !== 55) begin bad++; $display("[TB] FAIL loop_len got=%0d exp=55", cyc); end
    total++; if (csnLow !== 54) begin bad++; $display("[TB] FAIL loop_csn got=%0d exp=54", csnLow); end
    total++; if (toggles !== 16) begin bad++; $display("[TB] FAIL loop_sclk got=%0d exp=16", toggles); end
    total++; if (rdCnt !== 8 || wrCnt !== 7) begin bad++; $display("[TB] FAIL loop_edges got=%0d/%0d exp=8/7", rdCnt, wrCnt); end
    total++; if (sampleBad !== 0) begin bad++; $display("[TB] FAIL loop_sample got=%0d exp=0", sampleBad); end
    total++; if (cnt0 !== 0 || finalCount !== 8) begin bad++; $display("[TB] FAIL loop_count got=%0d/%0d exp=0/8", cnt0, finalCount); end
    total++; if (csn !== 1'b1 || ready_o !== 1'b1 || state_o !== 3'd4) begin
      bad++; $display("[TB] FAIL loop_done got=%b%b%0d exp=114", csn, ready_o, state_o); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] sent[$];
    logic [15:0] w0, exp;
    w0 = 16'($urandom);
    sent.push_back(w0);
    startFrame(w0, 8, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      runFrame(-1);
      exp = expRx(sent.pop_front(), 8);
      total++; if (rx !== exp) begin bad++; $display("[TB] FAIL b2b_data%0d got=%h exp=%h", i, rx, exp); end
      total++; if (cyc !== expLen(8, 1) || timedOut) begin bad++; $display("[TB] FAIL b2b_len%0d got=%0d exp=%0d", i, cyc, expLen(8, 1)); end
      if (i > 0) begin
        total++; if (csnLow !== expLen(8, 1) - 1) begin bad++; $display("[TB] FAIL b2b_csn%0d got=%0d exp=%0d", i, csnLow, expLen(8, 1) - 1); end
      end
      total++; if (csn !== 1'b1) begin bad++; $display("[TB] FAIL b2b_gap%0d got=%b exp=1", i, csn); end
      if (i < 4) begin
        mosi_data_i = 16'($urandom);
        sent.push_back(mosi_data_i);
        mosi_stb = 1'b1;
      end
    end
  endtask

  task automatic test_modes;
    logic [15:0] data;
    for (int m = 0; m < 4; m++) begin
      data = 16'($urandom);
      startFrame(data, 8, m[1], m[0], 0);
      runFrame(-1);
      total++; if (rx !== expRx(data, 8)) begin bad++; $display("[TB] FAIL mode%0d_data got=%h exp=%h", m, rx, expRx(data, 8)); end
      total++; if (sampleBad !== 0 || toggles !== 16) begin bad++; $display("[TB] FAIL mode%0d_sclk got=%0d/%0d exp=0/16", m, sampleBad, toggles); end
      total++; if (cyc !== expLen(8, 0)) begin bad++; $display("[TB] FAIL mode%0d_len got=%0d exp=%0d", m, cyc, expLen(8, 0)); end
      @(posedge clk); #1;
      total++; if (sclk !== m[1] || state_o !== 3'd0) begin bad++; $display("[TB] FAIL mode%0d_idle got=%b/%0d exp=%b/0", m, sclk, state_o, m[1]); end
    end
  endtask

  task automatic test_widths;
    int reqW[4] = '{1, 16, 0, 200};
    int effW[4] = '{1, 16, 1, 16};
    logic [15:0] data;
    for (int k = 0; k < 4; k++) begin
      data = 16'($urandom) | 16'h8001;
      startFrame(data, reqW[k], 1'b0, 1'b1, 1);
      runFrame(-1);
      total++; if (rx !== expRx(data, effW[k])) begin bad++; $display("[TB] FAIL width%0d_data got=%h exp=%h", reqW[k], rx, expRx(data, effW[k])); end
      total++; if (cyc !== expLen(effW[k], 1)) begin bad++; $display("[TB] FAIL width%0d_len got=%0d exp=%0d", reqW[k], cyc, expLen(effW[k], 1)); end
      total++; if (rdCnt !== effW[k] || wrCnt !== effW[k] - 1) begin
        bad++; $display("[TB] FAIL width%0d_edges got=%0d/%0d exp=%0d/%0d", reqW[k], rdCnt, wrCnt, effW[k], effW[k] - 1); end
    end
  endtask

  task automatic test_random;
    logic [15:0] data;
    int w, d;
    logic cp, ch;
    for (int k = 0; k < 6; k++) begin
      data = 16'($urandom);
      w  = int'($urandom_range(1, 16));
      d  = int'($urandom_range(0, 3));
      cp = 1'($urandom);
      ch = 1'($urandom);
      startFrame(data, w, cp, ch, d);
      runFrame(-1);
      total++; if (rx !== expRx(data, w)) begin bad++; $display("[TB] FAIL rand%0d_data w=%0d got=%h exp=%h", k, w, rx, expRx(data, w)); end
      total++; if (cyc !== expLen(w, d) || sampleBad !== 0) begin
        bad++; $display("[TB] FAIL rand%0d_timing got=%0d/%0d exp=%0d/0", k, cyc, sampleBad, expLen(w, d)); end
      total++; if (finalCount !== w) begin bad++; $display("[TB] FAIL rand%0d_count got=%0d exp=%0d", k, finalCount, w); end
    end
  endtask

  task automatic test_stb_ignored;
    logic [15:0] data;
    data = 16'h6B2D;
    startFrame(data, 8, 1'b1, 1'b0, 1);
    runFrame(6);
    total++; if (rx !== expRx(data, 8)) begin bad++; $display("[TB] FAIL stbmid_data got=%h exp=%h", rx, expRx(data, 8)); end
    total++; if (cyc !== expLen(8, 1)) begin bad++; $display("[TB] FAIL stbmid_len got=%0d exp=%0d", cyc, expLen(8, 1)); end
  endtask

  task automatic test_reset_mid;
    int stbSeen;
    startFrame(16'hF00F, 8, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    mosi_stb = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (state_o !== 3'd0 || csn !== 1'b1 || ready_o !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_state got=%0d/%b/%b exp=0/1/1", state_o, csn, ready_o); end
    total++; if (data_count_o !== 8'h0 || sclk !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_clear got=%0d/%b exp=0/0", data_count_o, sclk); end
    stbSeen = 0;
    for (int i = 0; i < 80; i++) begin
      if (miso_stb) stbSeen++;
      @(posedge clk); #1;
    end
    total++; if (stbSeen !== 0) begin bad++; $display("[TB] FAIL rstmid_nostb got=%0d exp=0", stbSeen); end
  endtask

  initial begin
    rst = 1'b1;
    spi_width_i = 8'd8;
    cpol_i = 1'b0;
    cpha_i = 1'b0;
    sclk_div_i = 16'd0;
    mosi_stb = 1'b0;
    mosi_data_i = 16'h0;
    curCpol = 1'b0;
    curCpha = 1'b0;
    test_reset;
    test_loopback;
    test_back_to_back;
    test_modes;
    test_widths;
    test_random;
    test_stb_ignored;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
